i2c_reg_slave: RTL

//   I2C target (responder) with a 256 x 8 register file and a 1-byte register pointer.
//   It answers the register write/read transactions that i2c_master issues
//   (chip addr, reg addr, data) and auto-increments the pointer after each byte.
//   It stands in for an ADV7513-style peripheral in loopback benches and gives the

---
 rtl/i2c_reg_slave.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C target with a 256 x 8 register file
// and an auto-incrementing register pointer.
module i2c_reg_slave #(
    parameter logic [6:0] CHIP_ADDR  = 7'h39,
    parameter int         FILTER_LEN = 3,
    parameter logic [7:0] REG_INIT   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oen,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, REG, ACK_R,
        WDATA, ACK_W, RDATA, ACK_M, IGNORE
    } state_t;

    state_t        st, st_n;
    logic [1:0]    s1, s2, flt, prv;
    logic [FW-1:0] fc [2];
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic [7:0]    tx, tx_n;
    logic [7:0]    ptr, ptr_n;
    logic [7:0]    byte_in;
    logic [7:0]    mem [256];
    logic          busy_n, oen_n, we;
    logic          scl_f, sda_f, prv_scl, prv_sda;
    logic          rise, fall, start, stop;

    assign sda_out = 1'b0;

    assign scl_f   = flt[0];
    assign sda_f   = flt[1];
    assign prv_scl = prv[0];
    assign prv_sda = prv[1];
    assign rise    = scl_f & ~prv_scl;
    assign fall    = ~scl_f & prv_scl;
    assign start   = scl_f & prv_scl & prv_sda & ~sda_f;
    assign stop    = scl_f & prv_scl & ~prv_sda & sda_f;

    // synchronize both pins, then accept a level once stable (bit 0 scl, bit 1 sda)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= '1;
            s2    <= '1;
            flt   <= '1;
            prv   <= '1;
            fc[0] <= '0;
            fc[1] <= '0;
        end else begin
            s1  <= {sda_in, scl_in};
            s2  <= s1;
            prv <= flt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == flt[i]) begin
                    fc[i] <= '0;
                end else if (fc[i] == FW'(FILTER_LEN - 1)) begin
                    flt[i] <= s2[i];
                    fc[i]  <= '0;
                end else begin
                    fc[i] <= fc[i] + FW'(1);
                end
            end
        end
    end

    // protocol state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            tx      <= '0;
            ptr     <= '0;
            busy    <= 1'b0;
            sda_oen <= 1'b1;
        end else begin
            st      <= st_n;
            cnt     <= cnt_n;
            sh      <= sh_n;
            tx      <= tx_n;
            ptr     <= ptr_n;
            busy    <= busy_n;
            sda_oen <= oen_n;
        end
    end

    // next state; SDA only moves on the cycle after a filtered SCL fall
    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        sh_n    = sh;
        tx_n    = tx;
        ptr_n   = ptr;
        busy_n  = busy;
        oen_n   = sda_oen;
        we      = 1'b0;
        byte_in = {sh[6:0], sda_f};
        if (stop) begin
            st_n   = IDLE;
            oen_n  = 1'b1;
            busy_n = 1'b0;
        end else if (start) begin
            st_n   = ADDR;
            cnt_n  = '0;
            oen_n  = 1'b1;
            busy_n = 1'b0;
        end else begin
            unique case (st)
                ADDR, REG, WDATA: begin
                    if (rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7 && st == REG)
                            ptr_n = byte_in;
                        if (cnt == 4'd7 && st == WDATA) begin
                            we    = 1'b1;
                            ptr_n = ptr + 8'd1;
                        end
                    end
                    if (fall && cnt == 4'd8) begin
                        cnt_n = '0;
                        oen_n = 1'b0;
                        if (st == REG) begin
                            st_n = ACK_R;
                        end else if (st == WDATA) begin
                            st_n = ACK_W;
                        end else if (sh[7:1] == CHIP_ADDR) begin
                            st_n   = ACK_A;
                            busy_n = 1'b1;
                        end else begin
                            st_n  = IGNORE;
                            oen_n = 1'b1;
                        end
                    end
                end
                ACK_A: begin
                    if (fall) begin
                        cnt_n = '0;
                        if (sh[0]) begin
                            st_n  = RDATA;
                            tx_n  = mem[ptr];
                            oen_n = mem[ptr][7];
                        end else begin
                            st_n  = REG;
                            oen_n = 1'b1;
                        end
                    end
                end
                ACK_R, ACK_W: begin
                    if (fall) begin
                        st_n  = WDATA;
                        cnt_n = '0;
                        oen_n = 1'b1;
                    end
                end
                RDATA: begin
                    if (rise)
                        cnt_n = cnt + 4'd1;
                    if (fall) begin
                        if (cnt == 4'd8) begin
                            st_n  = ACK_M;
                            oen_n = 1'b1;
                            ptr_n = ptr + 8'd1;
                        end else begin
                            tx_n  = {tx[6:0], tx[7]};
                            oen_n = tx[6];
                        end
                    end
                end
                ACK_M: begin
                    // cnt = 9 marks an ACK seen on the 9th rise
                    if (rise) begin
                        if (sda_f)
                            st_n = IGNORE;
                        else
                            cnt_n = 4'd9;
                    end
                    if (fall && cnt == 4'd9) begin
                        st_n  = RDATA;
                        cnt_n = '0;
                        tx_n  = mem[ptr];
                        oen_n = mem[ptr][7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // register file: I2C write port and registered local read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= REG_INIT;
            rd_data <= REG_INIT;
        end else begin
            if (we)
                mem[ptr] <= byte_in;
            rd_data <= mem[rd_addr];
        end
    end

    // one-cycle write notification aligned with the memory update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= we;
            if (we) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
            end
        end
    end
endmodule
